// File: rtl/axi_pkg.sv
// Shared AXI constants and read-arbiter types.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [3:0] ARID_I = 4'd0;
    localparam logic [3:0] ARID_D = 4'd1;

    // Full 32-bit beat size, used for every line burst.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } rd_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } rd_port_t;

endpackage

// File: rtl/axi_rd_line_buf.sv
// Line assembly buffer: clear, write one 32-bit word at the beat pointer, advance with wrap.
module axi_rd_line_buf #(
    parameter int WORDS     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    output logic [WORDS*32-1:0]   line
);

    logic [PTR_WIDTH-1:0] ptr_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_reg <= '0;
        end else if (wr_en) begin
            ptr_reg <= (ptr_reg == PTR_WIDTH'(WORDS - 1)) ? '0 : ptr_reg + PTR_WIDTH'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    word_reg <= '0;
                end else if (wr_en && ptr_reg == PTR_WIDTH'(gi)) begin
                    word_reg <= wr_data;
                end
            end

            assign line[gi*32 +: 32] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/mux_1h.sv
// One-hot select mux: exactly one sel bit is expected to be high.
module mux_1h #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0]        sel,
    input  logic [N-1:0][W-1:0] data,
    output logic [W-1:0]        out
);

    logic [N-1:0][W-1:0] masked;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = sel[gi] ? data[gi] : '0;
        end
    endgenerate

    always_comb begin
        out = '0;
        for (int k = 0; k < N; k++) begin
            out = out | masked[k];
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares one AXI AR/R channel pair between I-cache and D-cache refills,
// one outstanding read at a time, returning a whole line to the owner.
module axi_rd_arb
    import axi_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16,
    parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
    parameter int PTR_WIDTH      = $clog2(WORDS_PER_LINE),
    parameter int LINE_WIDTH     = WORDS_PER_LINE * 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_idle,
    output logic                  read_unfinish,

    input  logic                  i_rd_req,
    input  logic [31:0]           i_rd_addr,
    input  logic                  i_rd_burst,
    input  logic [1:0]            i_rd_size,
    output logic                  i_rd_rdy,
    output logic                  i_ret_valid,
    output logic [LINE_WIDTH-1:0] i_ret_data,

    input  logic                  d_rd_req,
    input  logic [31:0]           d_rd_addr,
    input  logic                  d_rd_burst,
    input  logic [1:0]            d_rd_size,
    output logic                  d_rd_rdy,
    output logic                  d_ret_valid,
    output logic [LINE_WIDTH-1:0] d_ret_data,

    output logic [3:0]            arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [31:0] LINE_MASK = ~32'(BYTES_PER_LINE - 1);

    rd_state_t   state_reg;
    rd_state_t   state_next;
    rd_port_t    last_grant_reg;
    rd_port_t    owner_reg;
    logic [31:0] addr_reg;
    logic        burst_reg;
    logic [1:0]  size_reg;

    logic grant;
    logic grant_i;
    logic grant_d;
    logic beat_wr;
    logic sel_ar;
    logic sel_r;
    logic sel_resp;
    logic sel_idle;
    logic sel_hold;

    logic [LINE_WIDTH-1:0] line;
    logic [4:0]            state_sel;
    logic [4:0][1:0]       state_src;
    logic [1:0]            state_mux;

    logic unused_axi;
    assign unused_axi = ^{rid, rresp};

    always_comb begin
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        beat_wr     = 1'b0;
        sel_ar      = 1'b0;
        sel_r       = 1'b0;
        sel_resp    = 1'b0;
        sel_idle    = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Tie goes to whichever port lost last time.
                if ((i_rd_req || d_rd_req) && wr_idle && !reset) begin
                    grant_d = d_rd_req && (!i_rd_req || last_grant_reg == PORT_I);
                    grant_i = !grant_d;
                    sel_ar  = 1'b1;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                sel_r   = arready;
            end
            ST_R: begin
                rready   = 1'b1;
                beat_wr  = rvalid;
                sel_resp = rvalid && rlast;
            end
            ST_RESP: begin
                i_ret_valid = (owner_reg == PORT_I);
                d_ret_valid = (owner_reg == PORT_D);
                sel_idle    = 1'b1;
            end
            default: ;
        endcase

        grant         = grant_i || grant_d;
        i_rd_rdy      = grant_i;
        d_rd_rdy      = grant_d;
        read_unfinish = (state_reg != ST_IDLE) || grant;
        sel_hold      = !(sel_ar || sel_r || sel_resp || sel_idle);
    end

    assign state_sel = {sel_hold, sel_idle, sel_resp, sel_r, sel_ar};
    assign state_src = {state_reg, ST_IDLE, ST_RESP, ST_R, ST_AR};

    mux_1h #(
        .N (5),
        .W (2)
    ) u_state_mux (
        .sel  (state_sel),
        .data (state_src),
        .out  (state_mux)
    );

    assign state_next = rd_state_t'(state_mux);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= PORT_I;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_grant_reg <= grant_d ? PORT_D : PORT_I;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            owner_reg <= grant_d ? PORT_D : PORT_I;
            addr_reg  <= grant_d ? d_rd_addr  : i_rd_addr;
            burst_reg <= grant_d ? d_rd_burst : i_rd_burst;
            size_reg  <= grant_d ? d_rd_size  : i_rd_size;
        end
    end

    assign arid    = (owner_reg == PORT_D) ? ARID_D : ARID_I;
    assign araddr  = burst_reg ? (addr_reg & LINE_MASK) : addr_reg;
    assign arlen   = burst_reg ? 8'(WORDS_PER_LINE - 1) : 8'd0;
    assign arsize  = burst_reg ? SIZE_WORD : {1'b0, size_reg};
    assign arburst = burst_reg ? BURST_INCR : BURST_FIXED;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    axi_rd_line_buf #(
        .WORDS     (WORDS_PER_LINE),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant),
        .wr_en   (beat_wr),
        .wr_data (rdata),
        .line    (line)
    );

    assign i_ret_data = line;
    assign d_ret_data = line;

endmodule
